// File: rtl/sr_fifo_arbiter.sv
// Two-requester push arbiter in front of a first-word-fall-through FIFO.
// Define SR_FIFO_ARB_RR_EN for round-robin grant; otherwise requester 0 has fixed priority.
module sr_fifo_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  input  logic [WIDTH-1:0]           req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [WIDTH-1:0]           req1_data,
  output logic                       req1_ready,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    headPtr;
  logic [AW-1:0]    tailPtr;
  logic             pick1;
  logic             pushEn;
  logic             popEn;
  logic [WIDTH-1:0] pushData;

`ifdef SR_FIFO_ARB_RR_EN
  typedef enum logic {PRIO_REQ0 = 1'b0, PRIO_REQ1 = 1'b1} prio_e;
  prio_e prioPtr;

  assign pick1 = req1_valid && (!req0_valid || prioPtr == PRIO_REQ1);

  always_ff @(posedge clk) begin
    if (rst)             prioPtr <= PRIO_REQ0;
    else if (req0_ready) prioPtr <= PRIO_REQ1;
    else if (req1_ready) prioPtr <= PRIO_REQ0;
  end
`else
  assign pick1 = req1_valid && !req0_valid;
`endif

  assign empty = (count == '0);
  assign full  = (count == (AW + 1)'(DEPTH));

  // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    pushData   = req0_data;
    if (!full) begin
      req1_ready = pick1;
      req0_ready = req0_valid && !pick1;
    end
    if (pick1) pushData = req1_data;
  end

  assign pushEn   = req0_ready || req1_ready;
  assign popEn    = pop && !empty;
  assign pop_data = mem[headPtr];

  // NOTE: storage is never reset; head/tail/count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (pushEn && !rst) mem[tailPtr] <= pushData;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (pushEn) tailPtr <= tailPtr + AW'(1);
      if (popEn)  headPtr <= headPtr + AW'(1);
      count <= count + {{AW{1'b0}}, pushEn} - {{AW{1'b0}}, popEn};
      if (pop && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sr_fifo_arbiter.sv
// Scoreboard bench for sr_fifo_arbiter: reference model updates on the rising edge,
// state checker and pop monitor compare on the falling edge.
module tb_sr_fifo_arbiter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    req0_valid = 1'b0;
  logic [WIDTH-1:0]        req0_data = '0;
  logic                    req0_ready;
  logic                    req1_valid = 1'b0;
  logic [WIDTH-1:0]        req1_data = '0;
  logic                    req1_ready;
  logic                    pop = 1'b0;
  logic [WIDTH-1:0]        pop_data;
  logic                    empty;
  logic                    full;
  logic [$clog2(DEPTH):0]  count;
  logic                    underflow;

  sr_fifo_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .pop(pop), .pop_data(pop_data), .empty(empty), .full(full),
    .count(count), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: occupancy as an integer, priority as a bit, data order as a queue.
  int               mCount = 0;
  bit               mPrio  = 1'b0;
  bit               mUnder = 1'b0;
  logic [WIDTH-1:0] expQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which requester the rules say is accepted right now: {req1, req0}.
  function automatic bit [1:0] expReady();
    bit win1;
    if (mCount >= DEPTH) return 2'b00;
`ifdef SR_FIFO_ARB_RR_EN
    win1 = req1_valid && (!req0_valid || mPrio);
`else
    win1 = req1_valid && !req0_valid;
`endif
    return {win1, req0_valid && !win1};
  endfunction

  always @(posedge clk) begin : model
    bit [1:0] g;
    bit       popOk;
    if (rst) begin
      mCount = 0;
      mPrio  = 1'b0;
      mUnder = 1'b0;
      expQ.delete();
    end else begin
      g     = expReady();
      popOk = pop && (mCount > 0);
      if (pop && mCount == 0) mUnder = 1'b1;
      if (g[0]) begin
        expQ.push_back(req0_data);
        mPrio = 1'b1;
      end else if (g[1]) begin
        expQ.push_back(req1_data);
        mPrio = 1'b0;
      end
      mCount = mCount + int'(g != 2'b00) - int'(popOk);
    end
  end

  always @(negedge clk) begin : stateChk
    bit [1:0] g;
    g = expReady();
    check("req0_ready", req0_ready, g[0]);
    check("req1_ready", req1_ready, g[1]);
    check("count", count, mCount);
    check("empty", empty, mCount == 0);
    check("full", full, mCount == DEPTH);
    check("underflow", underflow, mUnder);
  end

  always @(negedge clk) begin : popMonitor
    if (!rst && pop && !empty) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_data: got 0x%0h, expected no entry at %0t", pop_data, $time);
      end else begin
        check("pop_data", pop_data, expQ.pop_front());
      end
    end
  end

  task automatic drive(input bit v0, input logic [WIDTH-1:0] d0,
                       input bit v1, input logic [WIDTH-1:0] d1,
                       input bit p, input bit r);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    pop        = p;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (empty) break;
      drive(0, '0, 0, '0, 1, 0);
    end
    drive(0, '0, 0, '0, 0, 0);
    check("drain_empty", empty, 1'b1);
  endtask

  initial begin
    drive(0, '0, 0, '0, 0, 1);
    drive(0, '0, 0, '0, 0, 1);
    check("reset_count", count, 0);
    check("reset_empty", empty, 1'b1);

    // Basic FIFO order from requester 0.
    drive(1, 16'h0011, 0, '0, 0, 0);
    drive(1, 16'h0022, 0, '0, 0, 0);
    check("two_pushes_count", count, 2);
    drive(0, '0, 0, '0, 1, 0);
    drive(0, '0, 0, '0, 1, 0);
    drive(0, '0, 0, '0, 0, 0);
    check("two_pops_empty", empty, 1'b1);

    // Both requesters valid: arbitration order lands in the scoreboard.
    for (int i = 0; i < 4; i++)
      drive(1, 16'(16'hA000 + i), 1, 16'(16'hB000 + i), 0, 0);
    drain();

    // Fill from requester 1, then pop+push while full: push refused.
    for (int i = 0; i < DEPTH; i++) drive(0, '0, 1, 16'(16'hC000 + i), 0, 0);
    check("fill_full", full, 1'b1);
    drive(0, '0, 1, 16'hCFFF, 1, 0);
    check("full_pop_push_count", count, DEPTH - 1);
    drain();

    // Push and pop together while empty.
    drive(1, 16'h1234, 0, '0, 1, 0);
    check("empty_pushpop_count", count, 1);
    check("empty_pushpop_underflow", underflow, 1'b1);
    check("empty_pushpop_data", pop_data, 16'h1234);
    drain();
    drive(0, '0, 0, '0, 0, 1);
    check("underflow_cleared", underflow, 1'b0);

    // Steady occupancy of 3 with simultaneous push/pop, forcing pointer wrap.
    for (int i = 0; i < 3; i++) drive(1, 16'(16'hD000 + i), 0, '0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) drive(1, 16'(16'hE000 + i), 0, '0, 1, 0);
      else            drive(0, '0, 1, 16'(16'hE000 + i), 1, 0);
    end
    check("wrap_count", count, 3);
    drain();

    // Reset during a push with four entries held.
    for (int i = 0; i < 4; i++) drive(0, '0, 1, 16'(16'hF000 + i), 0, 0);
    drive(1, 16'hF0F0, 0, '0, 1, 1);
    check("midreset_count", count, 0);
    check("midreset_empty", empty, 1'b1);
    check("midreset_underflow", underflow, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1; rst = 1'b0; pop = 1'b0;
    #1;
    check("midreset_prio_req0", req0_ready, 1'b1);
    check("midreset_prio_req1", req1_ready, 1'b0);
    @(posedge clk);
    #1;
    drain();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 99) < 60, 16'($urandom),
            $urandom_range(0, 99) < 60, 16'($urandom),
            $urandom_range(0, 99) < 45, $urandom_range(0, 149) == 0);

    drain();
    check("scoreboard_empty", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
